// File: rtl/redirect_ctrl.sv
// Redirect sequencer from WB to IF: flushes, drains outstanding inst fetches, then issues the new PC.
// Optional REDIRECT_PERF_EN adds per-cause 32-bit event counters.
module redirect_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'hbfc00380,
   parameter int          MAX_OUTST  = 2,
   parameter int          CNT_W      = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ws_valid,
   input  logic        ws_excp_valid,
   input  logic        ws_inst_eret,
   input  logic        ws_tlb_refetch,
   input  logic [31:0] ws_refetch_pc,
   input  logic [31:0] cp0_epc,
   input  logic        inst_req_fire,
   input  logic        inst_data_ok,
   input  logic        if_redirect_ready,
   output logic        flush,
   output logic        fetch_block,
   output logic        resp_discard,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [1:0]  redirect_cause,
   output logic        busy,
   output logic [1:0]  state_dbg
`ifdef REDIRECT_PERF_EN
   ,
   output logic [31:0] perf_exc_cnt,
   output logic [31:0] perf_eret_cnt,
   output logic [31:0] perf_refetch_cnt
`endif
);

   // redirect_valid/if_redirect_ready: the PC transfers on a cycle where both are high;
   // redirect_pc and redirect_cause stay stable while redirect_valid waits for ready.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_ISSUE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] outst_cnt, cnt_d;
   logic             ev;
   logic [31:0]      tgt_pc;
   logic [1:0]       tgt_cause;

   assign ev        = ws_valid & (ws_excp_valid | ws_inst_eret | ws_tlb_refetch);
   assign state_dbg = state_q;

   always_comb begin
      tgt_pc    = ws_refetch_pc;
      tgt_cause = 2'b11;
      if (ws_excp_valid) begin
         tgt_pc    = EXC_VECTOR;
         tgt_cause = 2'b01;
      end else if (ws_inst_eret) begin
         tgt_pc    = cp0_epc;
         tgt_cause = 2'b10;
      end
   end

   // A simultaneous request and response cancel out; a stray data_ok at zero is ignored.
   always_comb begin
      cnt_d = outst_cnt;
      if (inst_req_fire && !inst_data_ok && outst_cnt != CNT_MAX)
         cnt_d = outst_cnt + CNT_ONE;
      else if (!inst_req_fire && inst_data_ok && outst_cnt != '0)
         cnt_d = outst_cnt - CNT_ONE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         outst_cnt <= '0;
      end else begin
         state_q   <= state_d;
         outst_cnt <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (ev) state_d = (cnt_d == '0) ? S_ISSUE : S_DRAIN;
         S_DRAIN: if (inst_data_ok && cnt_d == '0) state_d = S_ISSUE;
         S_ISSUE: if (if_redirect_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      flush          = 1'b0;
      fetch_block    = (outst_cnt == CNT_MAX);
      resp_discard   = 1'b0;
      redirect_valid = 1'b0;
      busy           = 1'b0;
      case (state_q)
         S_IDLE:  flush = ev;
         S_DRAIN: begin
            flush        = 1'b1;
            fetch_block  = 1'b1;
            resp_discard = inst_data_ok;
            busy         = 1'b1;
         end
         S_ISSUE: begin
            flush          = 1'b1;
            fetch_block    = 1'b1;
            redirect_valid = 1'b1;
            busy           = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         redirect_pc    <= '0;
         redirect_cause <= '0;
      end else if (state_q == S_IDLE && ev) begin
         redirect_pc    <= tgt_pc;
         redirect_cause <= tgt_cause;
      end else if (state_q == S_ISSUE && if_redirect_ready) begin
         redirect_cause <= '0;
      end
   end

`ifdef REDIRECT_PERF_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_exc_cnt     <= '0;
         perf_eret_cnt    <= '0;
         perf_refetch_cnt <= '0;
      end else if (state_q == S_IDLE && ev) begin
         case (tgt_cause)
            2'b01:   perf_exc_cnt     <= perf_exc_cnt + 32'd1;
            2'b10:   perf_eret_cnt    <= perf_eret_cnt + 32'd1;
            default: perf_refetch_cnt <= perf_refetch_cnt + 32'd1;
         endcase
      end
   end
`endif

endmodule
